// File: rtl/him_rmw_pipe_pkg.sv
// Shared definitions for the hit-info-memory append engine: default sizes,
// row/count types, clear FSM encoding and the parameter sanity check.
package him_rmw_pipe_pkg;

  localparam int ROW_BITS_DEF = 10;
  localparam int HIT_BITS_DEF = 16;
  localparam int SLOTS_DEF    = 8;
  localparam int CNT_BITS_DEF = 4;
  localparam int READ_LAT_DEF = 2;
  localparam int W_DEF        = SLOTS_DEF * HIT_BITS_DEF;

  typedef logic [ROW_BITS_DEF-1:0] row_t;
  typedef logic [CNT_BITS_DEF-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // The hit count must be able to represent SLOTS, and the RAM needs at least one read stage.
  function automatic bit paramsOk(input int slots, input int cntBits, input int readLat);
    return ((2 ** cntBits) > slots) && (readLat >= 1);
  endfunction

endpackage

// File: rtl/him_rmw_pipe_sdp_ram.sv
// Inferred simple dual-port RAM with a READ_LAT-deep registered read path.
module him_sdp_ram #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 128,
  parameter int READ_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wrAddr,
  input  logic [DATA_BITS-1:0] wrData,
  input  logic [ADDR_BITS-1:0] rdAddr,
  output logic [DATA_BITS-1:0] rdData
);

  logic [DATA_BITS-1:0] mem    [2**ADDR_BITS];
  logic [DATA_BITS-1:0] rdPipe [READ_LAT];

  // A read in the same cycle as a write to the same address returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
    rdPipe[0] <= mem[rdAddr];
    for (int i = 1; i < READ_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign rdData = rdPipe[READ_LAT-1];

endmodule

// File: rtl/him_rmw_pipe.sv
// HIM append engine: in-order read-modify-write pipeline with write-history
// forwarding, valid/ready request ports, sticky overflow and a whole-memory clear.
module him_rmw_pipe
  import him_rmw_pipe_pkg::*;
#(
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int HIT_BITS = HIT_BITS_DEF,
  parameter int SLOTS    = SLOTS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ROW_BITS-1:0]       wr_row,
  input  logic [CNT_BITS-1:0]       wr_nold,
  input  logic [CNT_BITS-1:0]       wr_nnew,
  input  logic [SLOTS*HIT_BITS-1:0] wr_hits,
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [ROW_BITS-1:0]       rd_row,
  output logic                      rsp_valid,
  output logic [ROW_BITS-1:0]       rsp_row,
  output logic [SLOTS*HIT_BITS-1:0] rsp_data,
  input  logic                      clear_start,
  output logic                      overflow,
  output logic                      busy
);

  localparam int W    = SLOTS * HIT_BITS;
  localparam int HIST = READ_LAT + 1;

  if (!paramsOk(SLOTS, CNT_BITS, READ_LAT)) begin : gBadParams
    $error("him_rmw_pipe: requires 2**CNT_BITS > SLOTS and READ_LAT >= 1");
  end

  typedef struct packed {
    logic                isWrite;
    logic [ROW_BITS-1:0] row;
    logic [CNT_BITS-1:0] nold;
    logic [W-1:0]        hits;
  } op_t;

  state_t              state;
  logic [ROW_BITS-1:0] clrCnt;

  logic [READ_LAT-1:0] stgValid;
  op_t                 stgOp [READ_LAT];

  logic                histValid [HIST];
  logic [ROW_BITS-1:0] histRow   [HIST];
  logic [W-1:0]        histData  [HIST];

  logic                acceptWr, acceptRd, anyValid;
  logic [CNT_BITS:0]   ovfSum;
  op_t                 newOp, wbOp;
  logic                wbValid, wbWrite, clearWrite, ramWe;
  logic [ROW_BITS-1:0] ramRdAddr, ramWrAddr;
  logic [W-1:0]        ramRdData, ramWrData, base, merged;

  assign wr_ready = (state == IDLE);
  assign rd_ready = (state == IDLE) && !wr_valid;
  assign acceptWr = wr_valid && wr_ready;
  assign acceptRd = rd_valid && rd_ready;
  assign anyValid = |stgValid;
  assign busy     = (state != IDLE) || anyValid;
  assign ovfSum   = {1'b0, wr_nold} + {1'b0, wr_nnew};

  assign newOp.isWrite = acceptWr;
  assign newOp.row     = acceptWr ? wr_row : rd_row;
  assign newOp.nold    = wr_nold;
  assign newOp.hits    = wr_hits;
  assign ramRdAddr     = newOp.row;

  always_ff @(posedge clk) begin
    if (reset) stgValid <= '0;
    else begin
      stgValid[0] <= acceptWr || acceptRd;
      for (int i = 1; i < READ_LAT; i++) stgValid[i] <= stgValid[i-1];
    end
    stgOp[0] <= newOp;
    for (int i = 1; i < READ_LAT; i++) stgOp[i] <= stgOp[i-1];
  end

  assign wbValid = stgValid[READ_LAT-1];
  assign wbOp    = stgOp[READ_LAT-1];

  // History slot 0 is the newest write, so scan oldest-first and let newer matches override.
  always_comb begin
    base = ramRdData;
    for (int i = HIST - 1; i >= 0; i--)
      if (histValid[i] && (histRow[i] == wbOp.row)) base = histData[i];
  end

  assign merged     = ((wbOp.nold == '0) ? '0 : base) | (wbOp.hits << (int'(wbOp.nold) * HIT_BITS));
  assign wbWrite    = wbValid && wbOp.isWrite && !reset;
  assign clearWrite = (state == CLEAR) && !reset;
  assign ramWe      = wbWrite || clearWrite;
  assign ramWrAddr  = clearWrite ? clrCnt : wbOp.row;
  assign ramWrData  = clearWrite ? '0 : merged;

  assign rsp_valid = wbValid && !wbOp.isWrite && !reset;
  assign rsp_row   = wbOp.row;
  assign rsp_data  = base;

  always_ff @(posedge clk) begin
    if (reset || (state == CLEAR)) begin
      for (int i = 0; i < HIST; i++) histValid[i] <= 1'b0;
    end else if (wbWrite) begin
      histValid[0] <= 1'b1;
      histRow[0]   <= wbOp.row;
      histData[0]  <= merged;
      for (int i = 1; i < HIST; i++) begin
        histValid[i] <= histValid[i-1];
        histRow[i]   <= histRow[i-1];
        histData[i]  <= histData[i-1];
      end
    end
  end

  // Clear FSM; overflow lives here because only reset or a finished clear may drop it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clrCnt   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acceptWr && (ovfSum > (CNT_BITS+1)'(SLOTS))) overflow <= 1'b1;
          if (clear_start) state <= DRAIN;
        end
        DRAIN: begin
          if (!anyValid) begin
            state  <= CLEAR;
            clrCnt <= '0;
          end
        end
        CLEAR: begin
          clrCnt <= clrCnt + 1'b1;
          if (&clrCnt) begin
            overflow <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  him_sdp_ram #(
    .ADDR_BITS (ROW_BITS),
    .DATA_BITS (W),
    .READ_LAT  (READ_LAT)
  ) uRam (
    .clk    (clk),
    .we     (ramWe),
    .wrAddr (ramWrAddr),
    .wrData (ramWrData),
    .rdAddr (ramRdAddr),
    .rdData (ramRdData)
  );

endmodule

// File: tb/tb_him_rmw_pipe.sv
// Directed bench for him_rmw_pipe: a shadow row model feeds a response
// scoreboard, with latency, overflow, clear and mid-operation reset checks.
module tb_him_rmw_pipe;
  import him_rmw_pipe_pkg::*;

  localparam int ROW_BITS = ROW_BITS_DEF;
  localparam int HIT_BITS = HIT_BITS_DEF;
  localparam int SLOTS    = SLOTS_DEF;
  localparam int CNT_BITS = CNT_BITS_DEF;
  localparam int READ_LAT = READ_LAT_DEF;
  localparam int W        = SLOTS * HIT_BITS;
  localparam int DEPTH    = 2 ** ROW_BITS;

  logic                clk = 1'b0;
  logic                reset;
  logic                wr_valid, wr_ready, rd_valid, rd_ready;
  logic [ROW_BITS-1:0] wr_row, rd_row, rsp_row;
  logic [CNT_BITS-1:0] wr_nold, wr_nnew;
  logic [W-1:0]        wr_hits, rsp_data;
  logic                rsp_valid, clear_start, overflow, busy;

  typedef struct {
    row_t         row;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         sbq [$];
  exp_t         monE;
  logic [W-1:0] model [DEPTH];
  logic [W-1:0] saved;
  bit           expOvf = 1'b0;
  int           checks = 0;
  int           failures = 0;
  int           cycleCnt = 0;
  int           busyCycles;

  him_rmw_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_row      (wr_row),
    .wr_nold     (wr_nold),
    .wr_nnew     (wr_nnew),
    .wr_hits     (wr_hits),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_row      (rd_row),
    .rsp_valid   (rsp_valid),
    .rsp_row     (rsp_row),
    .rsp_data    (rsp_data),
    .clear_start (clear_start),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slot-by-slot reference: new hits land in slots nold.., anything past the last slot is lost.
  function automatic logic [W-1:0] modelMerge(input logic [W-1:0] old, input int nold,
                                              input int nnew, input logic [W-1:0] hits);
    logic [W-1:0] r;
    r = (nold == 0) ? '0 : old;
    for (int j = 0; j < nnew && j < SLOTS; j++)
      if (nold + j < SLOTS) r[(nold+j)*HIT_BITS +: HIT_BITS] |= hits[j*HIT_BITS +: HIT_BITS];
    return r;
  endfunction

  function automatic logic [W-1:0] mkHits(input logic [15:0] h0, input logic [15:0] h1 = '0,
                                          input logic [15:0] h2 = '0);
    logic [W-1:0] r;
    r = '0;
    r[0*HIT_BITS +: HIT_BITS] = h0;
    r[1*HIT_BITS +: HIT_BITS] = h1;
    r[2*HIT_BITS +: HIT_BITS] = h2;
    return r;
  endfunction

  // Drives one request for one cycle; called just after a rising edge, returns just after the next.
  task automatic applyStimulus(input bit isWr, input int row, input int nold, input int nnew,
                               input logic [W-1:0] hits, input bit clr);
    wr_valid    = isWr;
    rd_valid    = !isWr;
    wr_row      = ROW_BITS'(row);
    rd_row      = ROW_BITS'(row);
    wr_nold     = CNT_BITS'(nold);
    wr_nnew     = CNT_BITS'(nnew);
    wr_hits     = hits;
    clear_start = clr;
    @(negedge clk);
    if (isWr) begin
      checkOutput("wr_ready", wr_ready, 1'b1);
      model[row] = modelMerge(model[row], nold, nnew, hits);
      if (nold + nnew > SLOTS) expOvf = 1'b1;
    end else begin
      checkOutput("rd_ready", rd_ready, 1'b1);
      sbq.push_back('{row: row_t'(row), data: model[row], due: cycleCnt + READ_LAT});
    end
    @(posedge clk);
    #1;
    wr_valid    = 1'b0;
    rd_valid    = 1'b0;
    clear_start = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checkOutput("rsp_has_expected", (sbq.size() != 0), 1'b1);
      if (sbq.size() != 0) begin
        monE = sbq.pop_front();
        checkOutput("rsp_row", rsp_row, monE.row);
        checkOutput("rsp_data", rsp_data, monE.data);
        checkOutput("rsp_latency", cycleCnt, monE.due);
      end
    end
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; clear_start = 1'b0;
    wr_row = '0; rd_row = '0; wr_nold = '0; wr_nnew = '0; wr_hits = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_wr_ready", wr_ready, 1'b1);
    checkOutput("reset_rd_ready", rd_ready, 1'b1);
    @(posedge clk); #1;

    // Single append then a later read of the same row.
    applyStimulus(1, 5, 0, 1, mkHits(16'hAAAA), 0);
    idleCycles(3);
    applyStimulus(0, 5, 0, 0, '0, 0);
    idleCycles(4);
    checkOutput("sb_drained_t1", sbq.size(), 0);

    // Back-to-back appends to one row, read immediately afterwards.
    applyStimulus(1, 7, 0, 1, mkHits(16'h0001), 0);
    applyStimulus(1, 7, 1, 1, mkHits(16'h0002), 0);
    applyStimulus(1, 7, 2, 1, mkHits(16'h0003), 0);
    applyStimulus(0, 7, 0, 0, '0, 0);
    applyStimulus(1, 7, 3, 2, mkHits(16'h0004, 16'h0005), 0);
    applyStimulus(0, 5, 0, 0, '0, 0);
    applyStimulus(0, 7, 0, 0, '0, 0);
    idleCycles(4);
    checkOutput("sb_drained_t2", sbq.size(), 0);

    // Simultaneous write and read: the write wins, the read goes through next cycle.
    wr_valid = 1'b1; rd_valid = 1'b1;
    wr_row = 9; rd_row = 9; wr_nold = 0; wr_nnew = 2; wr_hits = mkHits(16'h1234, 16'h5678);
    @(negedge clk);
    checkOutput("dual_rd_ready_low", rd_ready, 1'b0);
    checkOutput("dual_wr_ready_high", wr_ready, 1'b1);
    model[9] = modelMerge(model[9], 0, 2, mkHits(16'h1234, 16'h5678));
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("dual_rd_ready_next", rd_ready, 1'b1);
    sbq.push_back('{row: row_t'(9), data: model[9], due: cycleCnt + READ_LAT});
    @(posedge clk); #1;
    rd_valid = 1'b0;
    idleCycles(4);
    checkOutput("sb_drained_t3", sbq.size(), 0);

    // Overflow: slot 7 keeps hit0, later hits vanish, flag stays sticky.
    applyStimulus(1, 11, 0, 1, mkHits(16'h1111), 0);
    applyStimulus(1, 11, 7, 3, mkHits(16'h00B0, 16'h00B1, 16'h00B2), 0);
    idleCycles(1);
    @(negedge clk);
    checkOutput("overflow_set", overflow, expOvf);
    @(posedge clk); #1;
    applyStimulus(0, 11, 0, 0, '0, 0);
    applyStimulus(1, 11, 2, 1, mkHits(16'h2222), 0);
    applyStimulus(1, 12, 8, 1, mkHits(16'h3333), 0);
    applyStimulus(0, 11, 0, 0, '0, 0);
    idleCycles(4);
    @(negedge clk);
    checkOutput("overflow_sticky", overflow, 1'b1);
    @(posedge clk); #1;
    checkOutput("sb_drained_t4", sbq.size(), 0);

    // Clear with two operations in flight.
    applyStimulus(0, 7, 0, 0, '0, 0);
    applyStimulus(1, 5, 0, 1, mkHits(16'h7777), 1);
    busyCycles = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      @(negedge clk);
      if (i == 10) checkOutput("wr_ready_during_clear", wr_ready, 1'b0);
      if (busy !== 1'b1) break;
      busyCycles++;
    end
    checkOutput("clear_busy_span", (busyCycles >= DEPTH) && (busyCycles <= DEPTH + READ_LAT + 2), 1'b1);
    checkOutput("sb_drained_clear", sbq.size(), 0);
    foreach (model[i]) model[i] = '0;
    expOvf = 1'b0;
    checkOutput("overflow_cleared", overflow, expOvf);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, '0, 0);
    applyStimulus(0, 5, 0, 0, '0, 0);
    applyStimulus(0, 7, 0, 0, '0, 0);
    applyStimulus(0, 9, 0, 0, '0, 0);
    applyStimulus(0, 11, 0, 0, '0, 0);
    applyStimulus(0, DEPTH - 1, 0, 0, '0, 0);
    idleCycles(4);
    checkOutput("sb_drained_t5", sbq.size(), 0);

    // Reset one cycle after an append is accepted: the append must never land.
    saved = model[5];
    applyStimulus(1, 5, 0, 1, mkHits(16'h5555), 0);
    model[5] = saved;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_midop_rsp_valid", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_midop_busy", busy, 1'b0);
    @(posedge clk); #1;
    applyStimulus(0, 5, 0, 0, '0, 0);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("sb_drained_final", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
